rr_hold_arbiter: RTL and testbench

//   Round-robin arbiter that shares one resource between N requesters.
//   A winner keeps the grant while it holds its request, up to MAX_HOLD cycles.

---
 rtl/rr_hold_arbiter.sv | 134 +++++++++++++
 tb/tb_rr_hold_arbiter.sv | 306 ++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/rr_hold_arbiter.sv
// Round-robin arbiter with grant hold: the winner keeps the resource while it
// holds its request, up to MAX_HOLD cycles, then must pass through an idle cycle.
module rr_hold_arbiter #(
    parameter int unsigned N        = 4,
    parameter int unsigned MAX_HOLD = 8
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 en,
    input  logic [N-1:0]         req,
    output logic [N-1:0]         gnt,
    output logic                 gnt_valid,
    output logic [$clog2(N)-1:0] gnt_id,
    output logic                 timeout
);

    localparam int unsigned ID_W  = $clog2(N);
    localparam int unsigned CNT_W = (MAX_HOLD == 0) ? 1 : $clog2(MAX_HOLD + 1);

    typedef enum logic {
        IDLE = 1'b0,
        BUSY = 1'b1
    } state_e;

    state_e           state_q, state_d;
    logic [ID_W-1:0]  ptr_q, ptr_d;
    logic [CNT_W-1:0] hold_cnt_q, hold_cnt_d;
    logic [N-1:0]     gnt_q, gnt_d;
    logic             gnt_valid_q, gnt_valid_d;
    logic [ID_W-1:0]  gnt_id_q, gnt_id_d;
    logic             timeout_q, timeout_d;

    logic             found;
    logic [ID_W-1:0]  win;
    logic [ID_W:0]    sum;
    logic [ID_W-1:0]  next_ptr;

    // First requester at or after ptr in wrap order
    always_comb begin
        found = 1'b0;
        win   = '0;
        sum   = '0;
        for (int i = 0; i < N; i++) begin
            sum = {1'b0, ptr_q} + (ID_W+1)'(i);
            if (sum >= (ID_W+1)'(N)) begin
                sum = sum - (ID_W+1)'(N);
            end
            if (!found && req[sum[ID_W-1:0]]) begin
                found = 1'b1;
                win   = sum[ID_W-1:0];
            end
        end
    end

    assign next_ptr = (gnt_id_q == ID_W'(N - 1)) ? '0 : gnt_id_q + ID_W'(1);

    always_comb begin
        state_d     = state_q;
        ptr_d       = ptr_q;
        hold_cnt_d  = hold_cnt_q;
        gnt_d       = gnt_q;
        gnt_valid_d = gnt_valid_q;
        gnt_id_d    = gnt_id_q;
        timeout_d   = 1'b0;
        case (state_q)
            IDLE: begin
                gnt_d       = '0;
                gnt_valid_d = 1'b0;
                gnt_id_d    = '0;
                if (en && found) begin
                    state_d     = BUSY;
                    gnt_d[win]  = 1'b1;
                    gnt_valid_d = 1'b1;
                    gnt_id_d    = win;
                    hold_cnt_d  = CNT_W'(1);
                end
            end
            BUSY: begin
                // Release wins over timeout when both apply
                if (!en || !req[gnt_id_q]) begin
                    state_d     = IDLE;
                    gnt_d       = '0;
                    gnt_valid_d = 1'b0;
                    gnt_id_d    = '0;
                    ptr_d       = next_ptr;
                    hold_cnt_d  = '0;
                end else if (MAX_HOLD != 0 && hold_cnt_q == CNT_W'(MAX_HOLD)) begin
                    state_d     = IDLE;
                    gnt_d       = '0;
                    gnt_valid_d = 1'b0;
                    gnt_id_d    = '0;
                    ptr_d       = next_ptr;
                    hold_cnt_d  = '0;
                    timeout_d   = 1'b1;
                end else if (MAX_HOLD != 0 && hold_cnt_q != CNT_W'(MAX_HOLD)) begin
                    hold_cnt_d = hold_cnt_q + CNT_W'(1);
                end
            end
            default: begin
                state_d     = IDLE;
                gnt_d       = '0;
                gnt_valid_d = 1'b0;
                gnt_id_d    = '0;
                hold_cnt_d  = '0;
            end
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q     <= IDLE;
            ptr_q       <= '0;
            hold_cnt_q  <= '0;
            gnt_q       <= '0;
            gnt_valid_q <= 1'b0;
            gnt_id_q    <= '0;
            timeout_q   <= 1'b0;
        end else begin
            state_q     <= state_d;
            ptr_q       <= ptr_d;
            hold_cnt_q  <= hold_cnt_d;
            gnt_q       <= gnt_d;
            gnt_valid_q <= gnt_valid_d;
            gnt_id_q    <= gnt_id_d;
            timeout_q   <= timeout_d;
        end
    end

    assign gnt       = gnt_q;
    assign gnt_valid = gnt_valid_q;
    assign gnt_id    = gnt_id_q;
    assign timeout   = timeout_q;

endmodule

// File: tb/tb_rr_hold_arbiter.sv
// Bench for rr_hold_arbiter: directed scenarios plus random traffic against a
// cycle-level integer model of the arbitration rules.
module tb_rr_hold_arbiter;

    localparam int N        = 4;
    localparam int MAX_HOLD = 8;

    logic         clk;
    logic         rst;
    logic         en;
    logic [N-1:0] req;
    logic [N-1:0] gnt;
    logic         gnt_valid;
    logic [1:0]   gnt_id;
    logic         timeout;

    int errors;
    int checks;

    // Reference model: owner -1 means idle
    int m_owner;
    int m_ptr;
    int m_cnt;
    bit m_timeout;

    rr_hold_arbiter #(.N(N), .MAX_HOLD(MAX_HOLD)) dut (
        .clk       (clk),
        .rst       (rst),
        .en        (en),
        .req       (req),
        .gnt       (gnt),
        .gnt_valid (gnt_valid),
        .gnt_id    (gnt_id),
        .timeout   (timeout)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic logic [N-1:0] exp_gnt();
        logic [N-1:0] g;
        g = '0;
        if (m_owner >= 0) g[m_owner] = 1'b1;
        return g;
    endfunction

    function automatic logic [1:0] exp_id();
        return (m_owner >= 0) ? 2'(m_owner) : 2'd0;
    endfunction

    task automatic model_reset();
        m_owner   = -1;
        m_ptr     = 0;
        m_cnt     = 0;
        m_timeout = 0;
    endtask

    task automatic model_step();
        m_timeout = 0;
        if (rst) begin
            model_reset();
        end else if (m_owner < 0) begin
            if (en && req != '0) begin
                for (int i = 0; i < N; i++) begin
                    if (m_owner < 0 && req[(m_ptr + i) % N]) m_owner = (m_ptr + i) % N;
                end
                m_cnt = 1;
            end
        end else if (!en || !req[m_owner]) begin
            m_ptr   = (m_owner + 1) % N;
            m_owner = -1;
        end else if (MAX_HOLD != 0 && m_cnt == MAX_HOLD) begin
            m_ptr     = (m_owner + 1) % N;
            m_owner   = -1;
            m_timeout = 1;
        end else if (m_cnt < MAX_HOLD) begin
            m_cnt++;
        end
    endtask

    // Advance one clock; outputs are sampled 1 time unit after the edge
    task automatic tick();
        @(posedge clk);
        model_step();
        #1;
    endtask

    task automatic apply_reset();
        @(negedge clk);
        rst = 1'b1;
        req = '0;
        en  = 1'b1;
        model_reset();
        @(negedge clk);
        rst = 1'b0;
    endtask

    task automatic test_reset();
        apply_reset();
        checks++;
        if (gnt !== '0 || gnt_valid !== 1'b0 || gnt_id !== 2'd0 || timeout !== 1'b0) begin
            errors++;
            $display("FAIL reset_state: gnt=%b valid=%b id=%0d to=%b, required all zero",
                     gnt, gnt_valid, gnt_id, timeout);
        end
        for (int c = 0; c < 10; c++) begin
            tick();
            checks++;
            if (gnt !== 4'b0000 || gnt_valid !== 1'b0) begin
                errors++;
                $display("FAIL idle_no_req cyc%0d: gnt=%b valid=%b, required 0000/0", c, gnt, gnt_valid);
            end
        end
    endtask

    task automatic test_rotation();
        int order[$];
        int exp_order[5];
        int to_cnt;
        bit prev_valid;
        exp_order  = '{0, 1, 2, 3, 0};
        to_cnt     = 0;
        prev_valid = 0;
        apply_reset();
        req = 4'b1111;
        for (int c = 0; c < 44; c++) begin
            tick();
            checks++;
            if (gnt !== exp_gnt() || timeout !== m_timeout) begin
                errors++;
                $display("FAIL rotation cyc%0d: gnt=%b to=%b, required gnt=%b to=%b",
                         c, gnt, timeout, exp_gnt(), m_timeout);
            end
            if (gnt_valid && !prev_valid) order.push_back(int'(gnt_id));
            if (timeout) to_cnt++;
            prev_valid = gnt_valid;
        end
        checks++;
        if (order.size() != 5) begin
            errors++;
            $display("FAIL rotation_tenures: got %0d tenures, required 5", order.size());
        end else begin
            for (int k = 0; k < 5; k++) begin
                checks++;
                if (order[k] != exp_order[k]) begin
                    errors++;
                    $display("FAIL rotation_order[%0d]: id=%0d, required %0d", k, order[k], exp_order[k]);
                end
            end
        end
        checks++;
        if (to_cnt != 4) begin
            errors++;
            $display("FAIL rotation_timeouts: got %0d pulses, required 4", to_cnt);
        end
    endtask

    task automatic test_release_wrap();
        apply_reset();
        req = 4'b0100;
        for (int c = 0; c < 3; c++) begin
            tick();
            checks++;
            if (gnt !== 4'b0100 || gnt_id !== 2'd2) begin
                errors++;
                $display("FAIL release_hold cyc%0d: gnt=%b id=%0d, required 0100/2", c, gnt, gnt_id);
            end
        end
        req = 4'b0000;
        tick();
        checks++;
        if (gnt !== 4'b0000 || timeout !== 1'b0) begin
            errors++;
            $display("FAIL release_drop: gnt=%b to=%b, required 0000/0", gnt, timeout);
        end
        req = 4'b0101;
        tick();
        checks++;
        if (gnt !== 4'b0001 || gnt_id !== 2'd0) begin
            errors++;
            $display("FAIL release_wrap: gnt=%b id=%0d, required 0001/0", gnt, gnt_id);
        end
    endtask

    task automatic test_single_timeout();
        apply_reset();
        req = 4'b0010;
        for (int c = 0; c < 8; c++) begin
            tick();
            checks++;
            if (gnt !== 4'b0010 || timeout !== 1'b0) begin
                errors++;
                $display("FAIL single_hold cyc%0d: gnt=%b to=%b, required 0010/0", c, gnt, timeout);
            end
        end
        tick();
        checks++;
        if (gnt !== 4'b0000 || timeout !== 1'b1 || gnt_valid !== 1'b0) begin
            errors++;
            $display("FAIL single_timeout: gnt=%b to=%b valid=%b, required 0000/1/0", gnt, timeout, gnt_valid);
        end
        tick();
        checks++;
        if (gnt !== 4'b0010 || timeout !== 1'b0) begin
            errors++;
            $display("FAIL single_regrant: gnt=%b to=%b, required 0010/0", gnt, timeout);
        end
    endtask

    task automatic test_en_drop();
        apply_reset();
        req = 4'b0100;
        tick();
        checks++;
        if (gnt !== 4'b0100) begin
            errors++;
            $display("FAIL en_grant: gnt=%b, required 0100", gnt);
        end
        en = 1'b0;
        tick();
        checks++;
        if (gnt !== 4'b0000 || timeout !== 1'b0) begin
            errors++;
            $display("FAIL en_drop: gnt=%b to=%b, required 0000/0", gnt, timeout);
        end
        en  = 1'b1;
        req = 4'b0110;
        tick();
        checks++;
        if (gnt !== 4'b0010 || gnt_id !== 2'd1) begin
            errors++;
            $display("FAIL en_wrap: gnt=%b id=%0d, required 0010/1", gnt, gnt_id);
        end
    endtask

    task automatic test_async_reset();
        apply_reset();
        req = 4'b1000;
        tick();
        checks++;
        if (gnt !== 4'b1000 || gnt_id !== 2'd3) begin
            errors++;
            $display("FAIL arst_grant: gnt=%b id=%0d, required 1000/3", gnt, gnt_id);
        end
        #2;
        rst = 1'b1;
        model_reset();
        #1;
        checks++;
        if (gnt !== 4'b0000 || gnt_valid !== 1'b0 || gnt_id !== 2'd0) begin
            errors++;
            $display("FAIL arst_drop: gnt=%b valid=%b id=%0d, required 0000/0/0", gnt, gnt_valid, gnt_id);
        end
        @(negedge clk);
        rst = 1'b0;
        req = 4'b1001;
        tick();
        checks++;
        if (gnt !== 4'b0001 || gnt_id !== 2'd0) begin
            errors++;
            $display("FAIL arst_ptr: gnt=%b id=%0d, required 0001/0", gnt, gnt_id);
        end
    endtask

    task automatic test_random();
        apply_reset();
        for (int c = 0; c < 400; c++) begin
            for (int b = 0; b < N; b++) begin
                if ($urandom_range(0, 5) == 0) req[b] = ~req[b];
            end
            en = ($urandom_range(0, 19) != 0);
            tick();
            checks++;
            if (gnt !== exp_gnt() || gnt_id !== exp_id() || gnt_valid !== (m_owner >= 0)
                || timeout !== m_timeout) begin
                errors++;
                $display("FAIL random cyc%0d: gnt=%b id=%0d v=%b to=%b, required gnt=%b id=%0d v=%b to=%b",
                         c, gnt, gnt_id, gnt_valid, timeout, exp_gnt(), exp_id(), m_owner >= 0, m_timeout);
            end
            checks++;
            if (!$onehot0(gnt) || gnt_valid !== (|gnt) || (gnt_valid && !gnt[gnt_id])) begin
                errors++;
                $display("FAIL random_invariant cyc%0d: gnt=%b id=%0d v=%b", c, gnt, gnt_id, gnt_valid);
            end
        end
    endtask

    initial begin
        errors = 0;
        checks = 0;
        rst    = 1'b1;
        en     = 1'b0;
        req    = '0;
        model_reset();
        test_reset();
        test_rotation();
        test_release_wrap();
        test_single_timeout();
        test_en_drop();
        test_async_reset();
        test_random();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
